// File: rtl/mem_responder.sv
// Byte-serial memory bus target: single-port byte RAM plus an MMIO window
// with a TX byte FIFO, RX byte pop, status register and sticky halt flag.
module mem_responder #(
  parameter int ADDR_WIDTH  = 17,
  parameter int FIFO_DEPTH  = 8,
  parameter int FIFO_WIDTH  = 3,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        halt
);

  localparam logic [FIFO_WIDTH:0] DEPTH_C      = (FIFO_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [FIFO_WIDTH:0] FULL_LEVEL_C = (FIFO_WIDTH+1)'(FIFO_DEPTH - FULL_MARGIN);
  localparam logic [31:0]         IO_TX_ADDR   = 32'h0003_0000;
  localparam logic [31:0]         IO_STAT_ADDR = 32'h0003_0004;

  logic [7:0]            ram [2**ADDR_WIDTH];
  logic [7:0]            fifo_mem [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] head;
  logic [FIFO_WIDTH-1:0] tail;
  logic [FIFO_WIDTH:0]   count;
  logic [FIFO_WIDTH:0]   count_next;
  logic                  overflow;
  logic                  rx_pop_q;

  logic                  io_sel;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  ram_we;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic                  halt_req;
  logic                  rx_rd;
  logic [7:0]            rd_data;

  assign io_sel   = (mem_a[17:16] == 2'b11);
  assign ram_idx  = mem_a[ADDR_WIDTH-1:0];
  assign ram_we   = rdy_in && mem_wr && !io_sel;
  assign tx_valid = (count != '0);
  assign tx_data  = fifo_mem[head];
  assign pop      = rdy_in && tx_valid && tx_ready;
  assign push_req = rdy_in && mem_wr && (mem_a == IO_TX_ADDR);
  // A full FIFO still takes the byte when the sink drains one in the same cycle.
  assign push_ok  = push_req && ((count < DEPTH_C) || pop);
  assign halt_req = rdy_in && mem_wr && (mem_a == IO_STAT_ADDR);
  assign rx_rd    = !mem_wr && (mem_a == IO_TX_ADDR);
  assign rx_pop   = rx_pop_q && rdy_in;

  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_comb begin
    rd_data = 8'h00;
    if (!mem_wr) begin
      if (!io_sel)
        rd_data = ram[ram_idx];
      else if (mem_a == IO_TX_ADDR)
        rd_data = rx_valid ? rx_data : 8'h00;
      else if (mem_a == IO_STAT_ADDR)
        rd_data = {6'b0, overflow, (count == DEPTH_C)};
    end
  end

  // Storage arrays carry no reset; only pointers and flags do.
  always_ff @(posedge clk_in) begin
    if (ram_we)
      ram[ram_idx] <= mem_dout;
    if (push_ok)
      fifo_mem[tail] <= mem_dout;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_din        <= 8'h00;
      rx_pop_q       <= 1'b0;
      halt           <= 1'b0;
      overflow       <= 1'b0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      io_buffer_full <= 1'b0;
    end else if (!rdy_in) begin
      rx_pop_q <= 1'b0;
    end else begin
      mem_din  <= rd_data;
      rx_pop_q <= rx_rd && rx_valid;
      if (halt_req)
        halt <= 1'b1;
      if (push_req && !push_ok)
        overflow <= 1'b1;
      if (push_ok)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      count <= count_next;
      // Warns early enough to cover a store already in flight from the initiator.
      io_buffer_full <= (count_next >= FULL_LEVEL_C);
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: RAM streaming, TX FIFO
// fill/drain/overflow, RX pop, halt, rdy_in freeze and async reset.
module tb_mem_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        halt;

  int err_count   = 0;
  int check_count = 0;

  mem_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_pop(rx_pop), .halt(halt)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one bus transaction and return 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic [31:0] a, input logic wr, input logic [7:0] d);
    mem_a    = a;
    mem_wr   = wr;
    mem_dout = d;
    @(posedge clk_in);
    #1;
  endtask

  task automatic doReset();
    rst_in = 1'b1;
    mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rdy_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  logic [7:0] exp_q [$];

  initial begin
    doReset();
    checkOutput("reset mem_din", mem_din, 8'h00);
    checkOutput("reset halt", halt, 1'b0);
    checkOutput("reset tx_valid", tx_valid, 1'b0);
    checkOutput("reset full", io_buffer_full, 1'b0);
    checkOutput("reset rx_pop", rx_pop, 1'b0);

    // RAM write then streaming read with one cycle latency
    applyStimulus(32'h100, 1'b1, 8'h11);
    checkOutput("ram write mem_din", mem_din, 8'h00);
    applyStimulus(32'h101, 1'b1, 8'h22);
    applyStimulus(32'h102, 1'b1, 8'h33);
    applyStimulus(32'h103, 1'b1, 8'h44);
    applyStimulus(32'h100, 1'b0, 8'h00);
    checkOutput("stream 0x100", mem_din, 8'h11);
    applyStimulus(32'h101, 1'b0, 8'h00);
    checkOutput("stream 0x101", mem_din, 8'h22);
    applyStimulus(32'h102, 1'b0, 8'h00);
    checkOutput("stream 0x102", mem_din, 8'h33);
    applyStimulus(32'h103, 1'b0, 8'h00);
    checkOutput("stream 0x103", mem_din, 8'h44);

    applyStimulus(32'h200, 1'b1, 8'hAB);
    applyStimulus(32'h200, 1'b0, 8'h00);
    checkOutput("read after write", mem_din, 8'hAB);
    applyStimulus(32'h0002_0200, 1'b0, 8'h00);
    checkOutput("alias 0x20200", mem_din, 8'hAB);
    applyStimulus(32'hFF00_0103, 1'b0, 8'h00);
    checkOutput("upper bits ignored", mem_din, 8'h44);

    // Fill the TX FIFO with the sink stalled, then overflow it
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(32'h3_0000, 1'b1, 8'(i));
      if (i == 5) checkOutput("full after 5", io_buffer_full, 1'b0);
      if (i == 6) checkOutput("full after 6", io_buffer_full, 1'b1);
    end
    checkOutput("tx_valid filled", tx_valid, 1'b1);
    applyStimulus(32'h3_0000, 1'b1, 8'h99);
    applyStimulus(32'h3_0004, 1'b0, 8'h00);
    checkOutput("status overflow+full", mem_din, 8'h03);
    applyStimulus(32'h3_0008, 1'b0, 8'h00);
    checkOutput("unmapped io read", mem_din, 8'h00);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("drain %0d", i), tx_data, 8'(i));
      applyStimulus(32'h0, 1'b0, 8'h00);
    end
    checkOutput("drained tx_valid", tx_valid, 1'b0);
    checkOutput("drained full", io_buffer_full, 1'b0);

    // Push into a full FIFO while the sink pops in the same cycle
    doReset();
    for (int i = 1; i <= 8; i++) applyStimulus(32'h3_0000, 1'b1, 8'(i));
    tx_ready = 1'b1;
    applyStimulus(32'h3_0000, 1'b1, 8'h5A);
    tx_ready = 1'b0;
    applyStimulus(32'h3_0004, 1'b0, 8'h00);
    checkOutput("status full no ovf", mem_din, 8'h01);
    checkOutput("full held", io_buffer_full, 1'b1);
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h5A};
    tx_ready = 1'b1;
    foreach (exp_q[i]) begin
      checkOutput($sformatf("pushpop drain %0d", i), tx_data, 32'(exp_q[i]));
      applyStimulus(32'h0, 1'b0, 8'h00);
    end
    checkOutput("pushpop empty", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // RX pop
    rx_valid = 1'b1; rx_data = 8'h41;
    applyStimulus(32'h3_0000, 1'b0, 8'h00);
    checkOutput("rx data", mem_din, 8'h41);
    checkOutput("rx_pop pulse", rx_pop, 1'b1);
    rx_valid = 1'b0;
    applyStimulus(32'h100, 1'b0, 8'h00);
    checkOutput("rx_pop one cycle", rx_pop, 1'b0);
    applyStimulus(32'h3_0000, 1'b0, 8'h00);
    checkOutput("rx empty data", mem_din, 8'h00);
    checkOutput("rx empty no pop", rx_pop, 1'b0);

    // Halt, rdy_in freeze, then async reset mid-stream
    applyStimulus(32'h3_0004, 1'b1, 8'h00);
    checkOutput("halt set", halt, 1'b1);
    applyStimulus(32'h100, 1'b0, 8'h00);
    checkOutput("pre-freeze read", mem_din, 8'h11);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h101, 1'b0, 8'h00);
      checkOutput($sformatf("frozen %0d", i), mem_din, 8'h11);
    end
    rdy_in = 1'b1;
    applyStimulus(32'h101, 1'b0, 8'h00);
    checkOutput("post-freeze read", mem_din, 8'h22);
    checkOutput("halt sticky", halt, 1'b1);
    applyStimulus(32'h3_0000, 1'b1, 8'h77);
    rx_valid = 1'b1; rx_data = 8'h55;
    applyStimulus(32'h3_0000, 1'b0, 8'h00);
    checkOutput("pre-reset rx_pop", rx_pop, 1'b1);
    checkOutput("pre-reset tx_valid", tx_valid, 1'b1);
    mem_a = 32'h102;
    rst_in = 1'b1;
    #1;
    checkOutput("async rst mem_din", mem_din, 8'h00);
    checkOutput("async rst halt", halt, 1'b0);
    checkOutput("async rst tx_valid", tx_valid, 1'b0);
    checkOutput("async rst rx_pop", rx_pop, 1'b0);
    checkOutput("async rst full", io_buffer_full, 1'b0);
    rx_valid = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
